// File: rtl/tl_shrink_pkg.sv
// Shared TileLink-UH opcode constants and beat-count helpers for the source shrinker.
package tl_shrink_pkg;

  localparam logic [2:0] A_PUT_FULL         = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL      = 3'd1;
  localparam logic [2:0] A_ARITHMETIC       = 3'd2;
  localparam logic [2:0] A_LOGICAL          = 3'd3;
  localparam logic [2:0] A_GET              = 3'd4;
  localparam logic [2:0] A_HINT             = 3'd5;

  localparam logic [2:0] D_ACCESS_ACK       = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA  = 3'd1;
  localparam logic [2:0] D_HINT_ACK         = 3'd2;

  function automatic logic a_has_data(input logic [2:0] opcode);
    return opcode <= A_LOGICAL;
  endfunction

  function automatic logic d_has_data(input logic [2:0] opcode);
    return opcode == D_ACCESS_ACK_DATA;
  endfunction

  // Beats for a data-bearing message of 2^size bytes on a 2^lg_beat_bytes wide bus.
  function automatic int unsigned num_beats(input int unsigned size,
                                            input int unsigned lg_beat_bytes);
    if (size <= lg_beat_bytes) return 32'd1;
    return 32'd1 << (size - lg_beat_bytes);
  endfunction

endpackage

// File: rtl/tl_shrink_alloc.sv
// Busy table for the downstream source pool: lowest-free pick, set/clear, occupancy.
module tl_shrink_alloc #(
  parameter int IDX_W = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 alloc_en,
  input  logic                 release_en,
  input  logic [IDX_W-1:0]     release_idx,
  output logic [(1<<IDX_W)-1:0] busy,
  output logic                 any_free,
  output logic [IDX_W-1:0]     alloc_idx,
  output logic [IDX_W:0]       inflight
);

  localparam int N = 1 << IDX_W;

  logic [N-1:0] busy_q;
  logic [N-1:0] set_mask;
  logic [N-1:0] clr_mask;

  assign busy     = busy_q;
  assign any_free = ~&busy_q;

  always_comb begin
    alloc_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_idx = IDX_W'(i);
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < N; i++) begin
      inflight = inflight + (IDX_W+1)'(busy_q[i]);
    end
  end

  assign set_mask = alloc_en   ? (N'(1) << alloc_idx)   : '0;
  assign clr_mask = release_en ? (N'(1) << release_idx) : '0;

  // Clear before set: a stray release aimed at a free entry never cancels a fresh allocation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= (busy_q & ~clr_mask) | set_mask;
  end

endmodule

// File: rtl/tl_source_shrinker.sv
// TileLink-UH A/D source compactor: wide upstream IDs mapped onto a small downstream pool.
module tl_source_shrinker
  import tl_shrink_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SIZE_W    = 3,
  parameter int IN_SRC_W  = 5,
  parameter int OUT_SRC_W = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,

  input  logic                  in_a_valid,
  output logic                  in_a_ready,
  input  logic [2:0]            in_a_opcode,
  input  logic [2:0]            in_a_param,
  input  logic [SIZE_W-1:0]     in_a_size,
  input  logic [IN_SRC_W-1:0]   in_a_source,
  input  logic [ADDR_W-1:0]     in_a_address,
  input  logic [DATA_W/8-1:0]   in_a_mask,
  input  logic [DATA_W-1:0]     in_a_data,

  output logic                  out_a_valid,
  input  logic                  out_a_ready,
  output logic [2:0]            out_a_opcode,
  output logic [2:0]            out_a_param,
  output logic [SIZE_W-1:0]     out_a_size,
  output logic [OUT_SRC_W-1:0]  out_a_source,
  output logic [ADDR_W-1:0]     out_a_address,
  output logic [DATA_W/8-1:0]   out_a_mask,
  output logic [DATA_W-1:0]     out_a_data,

  input  logic                  out_d_valid,
  output logic                  out_d_ready,
  input  logic [2:0]            out_d_opcode,
  input  logic [1:0]            out_d_param,
  input  logic [SIZE_W-1:0]     out_d_size,
  input  logic [OUT_SRC_W-1:0]  out_d_source,
  input  logic                  out_d_sink,
  input  logic                  out_d_denied,
  input  logic                  out_d_corrupt,
  input  logic [DATA_W-1:0]     out_d_data,

  output logic                  in_d_valid,
  input  logic                  in_d_ready,
  output logic [2:0]            in_d_opcode,
  output logic [1:0]            in_d_param,
  output logic [SIZE_W-1:0]     in_d_size,
  output logic [IN_SRC_W-1:0]   in_d_source,
  output logic                  in_d_sink,
  output logic                  in_d_denied,
  output logic                  in_d_corrupt,
  output logic [DATA_W-1:0]     in_d_data,

  output logic [OUT_SRC_W:0]    inflight,
  output logic                  err
);

  localparam int N                     = 1 << OUT_SRC_W;
  localparam int CNT_W                 = 1 << SIZE_W;
  localparam int unsigned LG_BEAT      = $clog2(DATA_W / 8);

  logic [N-1:0]          busy;
  logic                  any_free;
  logic [OUT_SRC_W-1:0]  alloc_idx;
  logic                  alloc_en;
  logic                  release_en;

  logic [CNT_W-1:0]      a_cnt;
  logic [CNT_W-1:0]      d_cnt;
  logic [CNT_W-1:0]      a_beats_m1;
  logic [CNT_W-1:0]      d_beats_m1;
  logic [OUT_SRC_W-1:0]  a_hold;
  logic [IN_SRC_W-1:0]   orig_src [N];

  logic a_first, a_go, a_fire;
  logic d_first, d_last, d_fire;

  // Handshake contract on both channels: a beat transfers in the cycle valid and ready
  // are both high. Only valid is gated by pool state; ready never feeds back into valid.
  assign a_first     = (a_cnt == '0);
  assign a_go        = !a_first || any_free;
  assign out_a_valid = reset_n & in_a_valid & a_go;
  assign in_a_ready  = out_a_ready & a_go;
  assign a_fire      = out_a_valid & out_a_ready;
  assign alloc_en    = a_fire & a_first;

  assign out_a_opcode  = in_a_opcode;
  assign out_a_param   = in_a_param;
  assign out_a_size    = in_a_size;
  assign out_a_address = in_a_address;
  assign out_a_mask    = in_a_mask;
  assign out_a_data    = in_a_data;
  assign out_a_source  = a_first ? alloc_idx : a_hold;

  assign in_d_valid   = reset_n & out_d_valid;
  assign out_d_ready  = in_d_ready;
  assign d_fire       = in_d_valid & in_d_ready;
  assign in_d_opcode  = out_d_opcode;
  assign in_d_param   = out_d_param;
  assign in_d_size    = out_d_size;
  assign in_d_sink    = out_d_sink;
  assign in_d_denied  = out_d_denied;
  assign in_d_corrupt = out_d_corrupt;
  assign in_d_data    = out_d_data;
  assign in_d_source  = orig_src[out_d_source];

  always_comb begin
    a_beats_m1 = '0;
    d_beats_m1 = '0;
    if (a_has_data(in_a_opcode))
      a_beats_m1 = CNT_W'(num_beats(32'(in_a_size), LG_BEAT) - 32'd1);
    if (d_has_data(out_d_opcode))
      d_beats_m1 = CNT_W'(num_beats(32'(out_d_size), LG_BEAT) - 32'd1);
  end

  assign d_first    = (d_cnt == '0);
  assign d_last     = d_first ? (d_beats_m1 == '0) : (d_cnt == CNT_W'(1));
  assign release_en = d_fire & d_last;

  tl_shrink_alloc #(.IDX_W(OUT_SRC_W)) u_alloc (
    .clock       (clock),
    .reset_n     (reset_n),
    .alloc_en    (alloc_en),
    .release_en  (release_en),
    .release_idx (out_d_source),
    .busy        (busy),
    .any_free    (any_free),
    .alloc_idx   (alloc_idx),
    .inflight    (inflight)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_cnt  <= '0;
      a_hold <= '0;
    end else if (a_fire) begin
      if (a_first) begin
        a_cnt  <= a_beats_m1;
        a_hold <= alloc_idx;
      end else begin
        a_cnt  <= a_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d_cnt <= '0;
      err   <= 1'b0;
    end else if (d_fire) begin
      d_cnt <= d_first ? d_beats_m1 : d_cnt - CNT_W'(1);
      if (!busy[out_d_source]) err <= 1'b1;
    end
  end

  // Source table holds no control state, so it is left out of reset.
  always_ff @(posedge clock) begin
    if (alloc_en) orig_src[alloc_idx] <= in_a_source;
  end

endmodule

// File: tb/tb_tl_source_shrinker.sv
// Directed bench for tl_source_shrinker with a transaction-level reference model.
module tb_tl_source_shrinker;
  import tl_shrink_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;

  logic        in_a_valid, in_a_ready;
  logic [2:0]  in_a_opcode, in_a_param, in_a_size;
  logic [4:0]  in_a_source;
  logic [31:0] in_a_address, in_a_data;
  logic [3:0]  in_a_mask;

  logic        out_a_valid, out_a_ready;
  logic [2:0]  out_a_opcode, out_a_param, out_a_size;
  logic [1:0]  out_a_source;
  logic [31:0] out_a_address, out_a_data;
  logic [3:0]  out_a_mask;

  logic        out_d_valid, out_d_ready;
  logic [2:0]  out_d_opcode, out_d_size;
  logic [1:0]  out_d_param, out_d_source;
  logic        out_d_sink, out_d_denied, out_d_corrupt;
  logic [31:0] out_d_data;

  logic        in_d_valid, in_d_ready;
  logic [2:0]  in_d_opcode, in_d_size;
  logic [1:0]  in_d_param;
  logic [4:0]  in_d_source;
  logic        in_d_sink, in_d_denied, in_d_corrupt;
  logic [31:0] in_d_data;

  logic [2:0]  inflight;
  logic        err;

  int checks = 0;
  int errors = 0;

  tl_source_shrinker dut (
    .clock(clock), .reset_n(reset_n),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_opcode(in_a_opcode),
    .in_a_param(in_a_param), .in_a_size(in_a_size), .in_a_source(in_a_source),
    .in_a_address(in_a_address), .in_a_mask(in_a_mask), .in_a_data(in_a_data),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
    .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
    .out_d_param(out_d_param), .out_d_size(out_d_size), .out_d_source(out_d_source),
    .out_d_sink(out_d_sink), .out_d_denied(out_d_denied), .out_d_corrupt(out_d_corrupt),
    .out_d_data(out_d_data),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_opcode(in_d_opcode),
    .in_d_param(in_d_param), .in_d_size(in_d_size), .in_d_source(in_d_source),
    .in_d_sink(in_d_sink), .in_d_denied(in_d_denied), .in_d_corrupt(in_d_corrupt),
    .in_d_data(in_d_data),
    .inflight(inflight), .err(err)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pool occupancy, original IDs, and remaining-beat bookkeeping per channel.
  bit   [3:0] mbusy;
  logic [4:0] morig [4];
  bit   [3:0] mwritten = 4'h0;
  logic [1:0] ma_idx;
  int         ma_left;
  int         md_left;
  bit         merr;

  function automatic int m_beats(input logic [2:0] op, input logic [2:0] size, input bit is_d);
    int bytes;
    bit data;
    bytes = 1 << size;
    data  = is_d ? (op == 3'd1) : (op < 3'd4);
    if (!data || bytes <= 4) return 1;
    return bytes / 4;
  endfunction

  function automatic bit m_any_free();
    return mbusy != 4'hF;
  endfunction

  function automatic logic [1:0] m_lowest_free();
    for (int i = 0; i < 4; i++) if (!mbusy[i]) return 2'(i);
    return 2'd0;
  endfunction

  function automatic bit m_a_go();
    return (ma_left != 0) || m_any_free();
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mbusy   <= 4'h0;
      ma_idx  <= 2'd0;
      ma_left <= 0;
      md_left <= 0;
      merr    <= 1'b0;
    end else begin
      if (out_d_valid && in_d_ready) begin
        if (!mbusy[out_d_source]) merr <= 1'b1;
        if (md_left == 0) begin
          if (m_beats(out_d_opcode, out_d_size, 1'b1) == 1) mbusy[out_d_source] <= 1'b0;
          else md_left <= m_beats(out_d_opcode, out_d_size, 1'b1) - 1;
        end else begin
          if (md_left == 1) mbusy[out_d_source] <= 1'b0;
          md_left <= md_left - 1;
        end
      end
      // A freed entry only becomes visible next cycle: allocation looks at pre-edge state.
      if (in_a_valid && out_a_ready && m_a_go()) begin
        if (ma_left == 0) begin
          mbusy[m_lowest_free()]    <= 1'b1;
          morig[m_lowest_free()]    <= in_a_source;
          mwritten[m_lowest_free()] <= 1'b1;
          ma_idx  <= m_lowest_free();
          ma_left <= m_beats(in_a_opcode, in_a_size, 1'b0) - 1;
        end else begin
          ma_left <= ma_left - 1;
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model, away from the active edge.
  always @(negedge clock) begin
    if (reset_n) begin
      chk("a_valid", 64'(out_a_valid), 64'(in_a_valid & m_a_go()));
      chk("a_ready", 64'(in_a_ready), 64'(out_a_ready & m_a_go()));
      if (out_a_valid)
        chk("a_source", 64'(out_a_source), 64'((ma_left == 0) ? m_lowest_free() : ma_idx));
      chk("a_ctrl", 64'({out_a_opcode, out_a_param, out_a_size, out_a_mask}),
                    64'({in_a_opcode, in_a_param, in_a_size, in_a_mask}));
      chk("a_addr", 64'(out_a_address), 64'(in_a_address));
      chk("a_data", 64'(out_a_data), 64'(in_a_data));
      chk("d_hs", 64'({in_d_valid, out_d_ready}), 64'({out_d_valid, in_d_ready}));
      chk("d_ctrl", 64'({in_d_opcode, in_d_param, in_d_size, in_d_sink, in_d_denied, in_d_corrupt}),
                    64'({out_d_opcode, out_d_param, out_d_size, out_d_sink, out_d_denied, out_d_corrupt}));
      chk("d_data", 64'(in_d_data), 64'(out_d_data));
      if (in_d_valid && mwritten[out_d_source])
        chk("d_source", 64'(in_d_source), 64'(morig[out_d_source]));
      chk("inflight", 64'(inflight), 64'($countones(mbusy)));
      chk("err", 64'(err), 64'(merr));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_a(input logic [2:0] op, input logic [2:0] size, input logic [4:0] src);
    in_a_valid   = 1'b1;
    in_a_opcode  = op;
    in_a_param   = 3'($urandom_range(0, 7));
    in_a_size    = size;
    in_a_source  = src;
    in_a_address = $urandom;
    in_a_mask    = 4'($urandom_range(0, 15));
    in_a_data    = $urandom;
  endtask

  task automatic set_d(input logic [2:0] op, input logic [2:0] size, input logic [1:0] src);
    out_d_valid   = 1'b1;
    out_d_opcode  = op;
    out_d_param   = 2'($urandom_range(0, 3));
    out_d_size    = size;
    out_d_source  = src;
    out_d_sink    = 1'($urandom_range(0, 1));
    out_d_denied  = 1'b0;
    out_d_corrupt = 1'($urandom_range(0, 1));
    out_d_data    = $urandom;
  endtask

  // Single-beat AccessAck on each pool entry in turn, checking the restored source.
  task automatic drain(input logic [4:0] e0, input logic [4:0] e1,
                       input logic [4:0] e2, input logic [4:0] e3);
    logic [4:0] exp_src [4];
    exp_src[0] = e0; exp_src[1] = e1; exp_src[2] = e2; exp_src[3] = e3;
    for (int i = 0; i < 4; i++) begin
      set_d(D_ACCESS_ACK, 3'd2, 2'(i));
      #1;
      chk("drain_src", 64'(in_d_source), 64'(exp_src[i]));
      tick();
    end
    out_d_valid = 1'b0;
    #1;
    chk("drain_inflight", 64'(inflight), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fires;
    reset_n = 1'b0;
    set_a(A_GET, 3'd2, 5'h00);
    set_d(D_ACCESS_ACK, 3'd2, 2'd0);
    out_a_ready = 1'b1;
    in_d_ready  = 1'b1;

    // Pin the model's beat arithmetic with hand-derived values (4-byte bus).
    chk("beats_putfull16", 64'(m_beats(A_PUT_FULL, 3'd4, 1'b0)), 64'd4);
    chk("beats_get16",     64'(m_beats(A_GET, 3'd4, 1'b0)), 64'd1);
    chk("beats_ackdata8",  64'(m_beats(D_ACCESS_ACK_DATA, 3'd3, 1'b1)), 64'd2);
    chk("beats_ackdata1",  64'(m_beats(D_ACCESS_ACK_DATA, 3'd0, 1'b1)), 64'd1);

    tick(); tick(); tick();
    chk("rst_inflight", 64'(inflight), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_a_valid", 64'(out_a_valid), 64'd0);
    chk("rst_d_valid", 64'(in_d_valid), 64'd0);
    in_a_valid  = 1'b0;
    out_d_valid = 1'b0;
    reset_n     = 1'b1;
    tick();

    // Single Get and its reply.
    set_a(A_GET, 3'd2, 5'h17);
    #1;
    chk("t1_a_source", 64'(out_a_source), 64'd0);
    chk("t1_a_valid", 64'(out_a_valid), 64'd1);
    tick();
    in_a_valid = 1'b0;
    #1;
    chk("t1_inflight", 64'(inflight), 64'd1);
    set_d(D_ACCESS_ACK_DATA, 3'd2, 2'd0);
    #1;
    chk("t1_d_source", 64'(in_d_source), 64'h17);
    tick();
    out_d_valid = 1'b0;
    #1;
    chk("t1_inflight_done", 64'(inflight), 64'd0);

    // Fill the pool, stall a fifth request, release entry 2, reallocate it.
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: set_a(A_GET, 3'd2, 5'h03);
        1: set_a(A_GET, 3'd2, 5'h09);
        2: set_a(A_GET, 3'd2, 5'h11);
        default: set_a(A_GET, 3'd2, 5'h1F);
      endcase
      #1;
      chk("t2_alloc", 64'(out_a_source), 64'(i));
      tick();
    end
    set_a(A_GET, 3'd2, 5'h0A);
    #1;
    chk("t2_full_ready", 64'(in_a_ready), 64'd0);
    chk("t2_full_valid", 64'(out_a_valid), 64'd0);
    chk("t2_full_inflight", 64'(inflight), 64'd4);
    tick();
    set_d(D_ACCESS_ACK, 3'd2, 2'd2);
    #1;
    chk("t2_rel_src", 64'(in_d_source), 64'h11);
    chk("t2_rel_stall", 64'(in_a_ready), 64'd0);
    tick();
    out_d_valid = 1'b0;
    #1;
    chk("t2_realloc_src", 64'(out_a_source), 64'd2);
    chk("t2_realloc_ready", 64'(in_a_ready), 64'd1);
    tick();
    in_a_valid = 1'b0;
    #1;
    chk("t2_inflight", 64'(inflight), 64'd4);
    drain(5'h03, 5'h09, 5'h0A, 5'h1F);

    // 4-beat PutFull under a toggling downstream ready: one entry, one index.
    set_a(A_PUT_FULL, 3'd4, 5'h05);
    fires = 0;
    for (int c = 0; c < 20 && fires < 4; c++) begin
      out_a_ready = (c % 2) == 1;
      #1;
      if (out_a_valid) chk("t3_burst_src", 64'(out_a_source), 64'd0);
      if (in_a_valid && in_a_ready) fires++;
      tick();
      in_a_data = $urandom;
    end
    chk("t3_fires", 64'(fires), 64'd4);
    in_a_valid  = 1'b0;
    out_a_ready = 1'b1;
    #1;
    chk("t3_inflight", 64'(inflight), 64'd1);
    set_a(A_GET, 3'd2, 5'h08);
    #1;
    chk("t3_next_alloc", 64'(out_a_source), 64'd1);
    in_a_valid = 1'b0;
    set_d(D_ACCESS_ACK, 3'd2, 2'd0);
    #1;
    chk("t3_d_src", 64'(in_d_source), 64'h05);
    tick();
    out_d_valid = 1'b0;
    #1;
    chk("t3_inflight_done", 64'(inflight), 64'd0);

    // Two-beat AccessAckData: entry stays busy until the final beat.
    set_a(A_GET, 3'd3, 5'h0C);
    tick();
    in_a_valid = 1'b0;
    set_d(D_ACCESS_ACK_DATA, 3'd3, 2'd0);
    #1;
    chk("t4_beat1_src", 64'(in_d_source), 64'h0C);
    tick();
    chk("t4_mid_inflight", 64'(inflight), 64'd1);
    out_d_data = $urandom;
    #1;
    chk("t4_beat2_src", 64'(in_d_source), 64'h0C);
    tick();
    out_d_valid = 1'b0;
    #1;
    chk("t4_inflight_done", 64'(inflight), 64'd0);

    // Same-cycle last-beat release of entry 1 and a new request on a full pool.
    for (int i = 0; i < 4; i++) begin
      set_a(A_GET, 3'd2, 5'(16 + i));
      tick();
    end
    in_a_valid = 1'b0;
    set_d(D_ACCESS_ACK_DATA, 3'd3, 2'd1);
    #1;
    chk("t5_beat1_src", 64'(in_d_source), 64'h11);
    tick();
    chk("t5_mid_inflight", 64'(inflight), 64'd4);
    set_a(A_GET, 3'd2, 5'h1E);
    #1;
    chk("t5_same_cycle_ready", 64'(in_a_ready), 64'd0);
    chk("t5_same_cycle_valid", 64'(out_a_valid), 64'd0);
    tick();
    out_d_valid = 1'b0;
    #1;
    chk("t5_realloc_src", 64'(out_a_source), 64'd1);
    chk("t5_realloc_ready", 64'(in_a_ready), 64'd1);
    tick();
    in_a_valid = 1'b0;
    #1;
    chk("t5_inflight", 64'(inflight), 64'd4);
    drain(5'h10, 5'h1E, 5'h12, 5'h13);

    // Reply on a free entry: flagged, forwarded with the stale source, sticky.
    set_d(D_ACCESS_ACK, 3'd2, 2'd3);
    #1;
    chk("t6_stale_src", 64'(in_d_source), 64'h13);
    chk("t6_err_before", 64'(err), 64'd0);
    tick();
    out_d_valid = 1'b0;
    #1;
    chk("t6_err_set", 64'(err), 64'd1);
    tick(); tick();
    chk("t6_err_sticky", 64'(err), 64'd1);

    // Asynchronous reset mid-cycle with an entry held and a request pending.
    set_a(A_GET, 3'd2, 5'h04);
    tick();
    chk("t6_pre_rst_inflight", 64'(inflight), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_err", 64'(err), 64'd0);
    chk("t6_rst_inflight", 64'(inflight), 64'd0);
    chk("t6_rst_a_valid", 64'(out_a_valid), 64'd0);
    in_a_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("t6_post_inflight", 64'(inflight), 64'd0);
    chk("t6_post_err", 64'(err), 64'd0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
